alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 179 +++++++++++++++++
 tb/tb_alu_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake: single-cycle logic/arithmetic ops and
// an iterative shift-add multiplier, all results registered together with their flags.
module alu_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] o,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             n,
    output logic             err
);

    localparam int CW  = $clog2(WIDTH + 1);
    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_NOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_RSV0 = 4'd10;
    localparam logic [3:0] OP_RSV1 = 4'd11;
    localparam logic [3:0] OP_INC  = 4'd12;
    localparam logic [3:0] OP_DEC  = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_SLT  = 4'd15;

    typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

    state_t               state;
    logic                 rst_sync;
    logic                 accept;
    logic [WIDTH-1:0]     rhs;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       dif;
    logic [WIDTH-1:0]     alu_o;
    logic                 alu_c;
    logic                 alu_v;
    logic                 alu_err;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;

    // Reset asserts immediately but releases only on a clock edge, so the FSM
    // never sees a deassertion that races the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
        end
    end

    assign in_ready = rst_sync && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept   = in_valid && in_ready;

    // NOTE: every output of an always_comb gets a default first; a path that
    // leaves a variable unassigned would otherwise infer a latch.
    always_comb begin
        rhs     = ((opr == OP_INC) || (opr == OP_DEC)) ? WIDTH'(1) : b;
        sum     = {1'b0, a} + {1'b0, rhs};
        dif     = {1'b0, a} - {1'b0, rhs};
        alu_o   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (opr)
            OP_ADD, OP_INC: begin
                alu_o = sum[WIDTH-1:0];
                alu_c = sum[WIDTH];
                alu_v = (a[MSB] == rhs[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_DEC: begin
                alu_o = dif[WIDTH-1:0];
                alu_c = dif[WIDTH];
                alu_v = (a[MSB] != rhs[MSB]) && (dif[MSB] != a[MSB]);
            end
            OP_AND:  alu_o = a & b;
            OP_OR:   alu_o = a | b;
            OP_XOR:  alu_o = a ^ b;
            OP_NAND: alu_o = ~(a & b);
            OP_NOR:  alu_o = ~(a | b);
            OP_XNOR: alu_o = ~(a ^ b);
            OP_SHL: begin
                alu_o = a << 1;
                alu_c = a[MSB];
            end
            OP_SHR: begin
                alu_o = a >> 1;
                alu_c = a[0];
            end
            OP_RSV0, OP_RSV1: alu_err = 1'b1;
            OP_SLT:  alu_o = WIDTH'(a < b);
            default: alu_o = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values that existed before the edge.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            o         <= '0;
            z         <= 1'b0;
            c         <= 1'b0;
            v         <= 1'b0;
            n         <= 1'b0;
            err       <= 1'b0;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept && (opr == OP_MUL)) begin
                        state     <= MUL;
                        out_valid <= 1'b0;
                        mcand     <= {{WIDTH{1'b0}}, a};
                        mplier    <= b;
                        acc       <= '0;
                        cnt       <= '0;
                    end else if (accept) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        o         <= alu_o;
                        z         <= (alu_o == '0);
                        c         <= alu_c;
                        v         <= alu_v;
                        n         <= alu_o[MSB];
                        err       <= alu_err;
                    end else if ((state == HOLD) && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    // WIDTH shift-add iterations, then one cycle to publish the product.
                    if (cnt == CW'(WIDTH)) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        o         <= acc[WIDTH-1:0];
                        z         <= (acc[WIDTH-1:0] == '0);
                        c         <= |acc[2*WIDTH-1:WIDTH];
                        v         <= 1'b0;
                        n         <= acc[MSB];
                        err       <= 1'b0;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=4: hand-computed vectors covering every
// opcode, multiply latency, backpressure, back-to-back streaming and reset abort.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] opr;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] o;
    logic       z;
    logic       c;
    logic       v;
    logic       n;
    logic       err;
    logic [4:0] flags;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] va;
        logic [3:0] vb;
        logic [3:0] eo;
        logic [4:0] ef;
    } vec_t;

    // flags are packed as {z, c, v, n, err}
    vec_t stream [14] = '{
        '{4'd0,  4'hA, 4'h6, 4'h0, 5'b11000},
        '{4'd1,  4'hA, 4'h6, 4'h4, 5'b00100},
        '{4'd2,  4'hA, 4'h6, 4'h2, 5'b00000},
        '{4'd3,  4'hA, 4'h6, 4'hE, 5'b00010},
        '{4'd4,  4'hA, 4'h6, 4'hC, 5'b00010},
        '{4'd5,  4'hA, 4'h6, 4'hD, 5'b00010},
        '{4'd6,  4'hA, 4'h6, 4'h1, 5'b00000},
        '{4'd7,  4'hA, 4'h6, 4'h3, 5'b00000},
        '{4'd8,  4'hA, 4'h6, 4'h4, 5'b01000},
        '{4'd9,  4'hA, 4'h6, 4'h5, 5'b00000},
        '{4'd12, 4'hA, 4'h6, 4'hB, 5'b00010},
        '{4'd13, 4'hA, 4'h6, 4'h9, 5'b00010},
        '{4'd15, 4'hA, 4'h6, 4'h0, 5'b10000},
        '{4'd12, 4'h7, 4'h0, 4'h8, 5'b00110}
    };

    assign flags = {z, c, v, n, err};

    alu_pipe #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opr       (opr),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o         (o),
        .z         (z),
        .c         (c),
        .v         (v),
        .n         (n),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op_run(input string tag, input logic [3:0] t_op, input logic [3:0] t_a,
                          input logic [3:0] t_b, input logic [3:0] e_o, input logic [4:0] e_f);
        opr      = t_op;
        a        = t_a;
        b        = t_b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_o"}, 32'(o), 32'(e_o));
        check({tag, "_flags"}, 32'(flags), 32'(e_f));
    endtask

    task automatic mul_run(input string tag, input logic [3:0] t_a, input logic [3:0] t_b,
                           input logic [3:0] e_o, input logic [4:0] e_f);
        opr      = 4'd14;
        a        = t_a;
        b        = t_b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
            check({tag, "_busy_valid"}, 32'(out_valid), 32'd0);
        end
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_o"}, 32'(o), 32'(e_o));
        check({tag, "_flags"}, 32'(flags), 32'(e_f));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opr       = 4'd0;
        a         = 4'd0;
        b         = 4'd0;

        // Reset state, then synchronised release
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_o", 32'(o), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_rdy", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_rdy_pre", 32'(in_ready), 32'd0);
        tick();
        check("rel_rdy", 32'(in_ready), 32'd1);
        check("rel_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        op_run("add",   4'd0,  4'd3, 4'd2, 4'd5,  5'b00000);
        op_run("sub",   4'd1,  4'd2, 4'd3, 4'hF,  5'b01010);
        op_run("addov", 4'd0,  4'd7, 4'd1, 4'h8,  5'b00110);

        mul_run("mul32", 4'd3, 4'd2, 4'd6, 5'b00000);
        mul_run("mul54", 4'd5, 4'd4, 4'd4, 5'b01000);

        op_run("illegal", 4'd10, 4'd3, 4'd2, 4'd0, 5'b10001);
        op_run("slt",     4'd15, 4'd2, 4'd3, 4'd1, 5'b00000);

        // Drain to IDLE, then stall the consumer with a new request waiting
        tick();
        out_ready = 1'b0;
        opr       = 4'd4;
        a         = 4'd3;
        b         = 4'd2;
        in_valid  = 1'b1;
        tick();
        opr = 4'd0;
        a   = 4'd1;
        b   = 4'd1;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_o", 32'(o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_o", 32'(o), 32'd1);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_o", 32'(o), 32'd2);

        // Back-to-back stream, one result per cycle
        for (int i = 0; i < 14; i++) begin
            check("stream_rdy", 32'(in_ready), 32'd1);
            op_run("stream", stream[i].op, stream[i].va, stream[i].vb, stream[i].eo, stream[i].ef);
        end

        // Reset two cycles into a multiply
        opr      = 4'd14;
        a        = 4'd3;
        b        = 4'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_o", 32'(o), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_rel_rdy", 32'(in_ready), 32'd1);
        check("abort_rel_valid", 32'(out_valid), 32'd0);
        op_run("inc_wrap", 4'd12, 4'hF, 4'd0, 4'd0, 5'b11000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
